// File: rtl/tree_node_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tree_node_pkg : shared types/constants for the tree dispatch node      |
// | Revision      : 1.0                                                    |
// +-----------------------------------------------------------------------+
package tree_node_pkg;

   typedef enum logic [0:0] {
      TN_IDLE        = 1'b0,
      TN_BCAST_DRAIN = 1'b1
   } tn_state_e;

   localparam int CNT_W    = 16;
   localparam int CREDIT_W = 4;

endpackage
`default_nettype wire

// File: rtl/tree_node_slot.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tree_node_slot : one-entry child output slot with credit counter and   |
// |                  optional delivery counter (TREE_NODE_STATS_EN)         |
// | Revision       : 1.0                                                   |
// +-----------------------------------------------------------------------+
module tree_node_slot
   import tree_node_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int CREDITS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              m_ready_i,
   input  logic              done_i,
   output logic              m_valid_o,
   output logic [DATA_W-1:0] m_data_o,
   output logic              credit_ok_o,
   output logic              credit_err_o,
   output logic [CNT_W-1:0]  stat_o
);

   localparam logic [CREDIT_W-1:0] C_CREDIT_MAX = CREDIT_W'(CREDITS);

   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                w_drain;
   logic                w_credit_err;

   assign w_drain = valid_q & m_ready_i;

   // The top only loads an empty slot, so load and drain never coincide.
   always_comb begin
      valid_d      = valid_q;
      data_d       = data_q;
      credit_d     = credit_q;
      w_credit_err = 1'b0;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (w_drain) begin
         valid_d = 1'b0;
      end
      case ({load_i, done_i})
         2'b10: credit_d = credit_q - 1'b1;
         2'b01: begin
            if (credit_q == C_CREDIT_MAX) w_credit_err = 1'b1;
            else                          credit_d = credit_q + 1'b1;
         end
         default: credit_d = credit_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         data_q   <= '0;
         credit_q <= C_CREDIT_MAX;
      end else begin
         valid_q  <= valid_d;
         data_q   <= data_d;
         credit_q <= credit_d;
      end
   end

   assign m_valid_o    = valid_q;
   assign m_data_o     = data_q;
   assign credit_ok_o  = (credit_q != '0);
   assign credit_err_o = w_credit_err;

`ifdef TREE_NODE_STATS_EN
   logic [CNT_W-1:0] stat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      stat_q <= '0;
      else if (w_drain && stat_q != '1) stat_q <= stat_q + 1'b1;
   end

   assign stat_o = stat_q;
`else
   assign stat_o = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/tree_node_dispatch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tree_node_dispatch : unicast/broadcast fan-out node with per-child     |
// |                      credits; TREE_NODE_STATS_EN enables stat_cnt       |
// | Revision           : 1.0                                               |
// +-----------------------------------------------------------------------+
module tree_node_dispatch
   import tree_node_pkg::*;
#(
   parameter int NUM_CHILDREN = 5,
   parameter int DATA_W       = 32,
   parameter int CREDITS      = 4,
   parameter int SEL_W        = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [DATA_W-1:0]              s_data,
   input  logic [SEL_W-1:0]               s_dest,
   input  logic                           s_bcast,
   output logic [NUM_CHILDREN-1:0]        m_valid,
   input  logic [NUM_CHILDREN-1:0]        m_ready,
   output logic [NUM_CHILDREN*DATA_W-1:0] m_data,
   input  logic [NUM_CHILDREN-1:0]        done_i,
   output logic                           busy,
   output logic                           err_dest,
   output logic                           err_credit,
   output logic [NUM_CHILDREN*CNT_W-1:0]  stat_cnt
);

   tn_state_e                state_q, state_d;
   logic                     err_dest_q, err_credit_q;
   logic                     w_ready;
   logic                     w_accept;
   logic                     w_dest_ok;
   logic [NUM_CHILDREN-1:0]  w_load;
   logic [NUM_CHILDREN-1:0]  w_credit_ok;
   logic [NUM_CHILDREN-1:0]  w_credit_err;

   assign w_dest_ok = (int'(s_dest) < NUM_CHILDREN);

   always_comb begin
      state_d = state_q;
      w_ready = 1'b0;
      case (state_q)
         TN_IDLE: begin
            if (s_bcast) begin
               w_ready = ~(|m_valid) & (&w_credit_ok);
               if (s_valid && w_ready) state_d = TN_BCAST_DRAIN;
            end else if (!w_dest_ok) begin
               w_ready = 1'b1;
            end else begin
               w_ready = ~m_valid[s_dest] & w_credit_ok[s_dest];
            end
         end
         // Leave once every slot still holding the broadcast drains this cycle.
         TN_BCAST_DRAIN: begin
            if ((m_valid & ~m_ready) == '0) state_d = TN_IDLE;
         end
         default: state_d = TN_IDLE;
      endcase
   end

   assign s_ready  = rst_n & w_ready;
   assign w_accept = s_valid & s_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= TN_IDLE;
         err_dest_q   <= 1'b0;
         err_credit_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         err_dest_q   <= w_accept & ~s_bcast & ~w_dest_ok;
         err_credit_q <= err_credit_q | (|w_credit_err);
      end
   end

   generate
      for (genvar i = 0; i < NUM_CHILDREN; i++) begin : g_child
         assign w_load[i] = w_accept & (s_bcast | (w_dest_ok & (s_dest == SEL_W'(i))));

         tree_node_slot #(
            .DATA_W  (DATA_W),
            .CREDITS (CREDITS)
         ) u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .load_i       (w_load[i]),
            .data_i       (s_data),
            .m_ready_i    (m_ready[i]),
            .done_i       (done_i[i]),
            .m_valid_o    (m_valid[i]),
            .m_data_o     (m_data[i*DATA_W +: DATA_W]),
            .credit_ok_o  (w_credit_ok[i]),
            .credit_err_o (w_credit_err[i]),
            .stat_o       (stat_cnt[i*CNT_W +: CNT_W])
         );
      end
   endgenerate

   assign busy       = (|m_valid) | (state_q != TN_IDLE);
   assign err_dest   = err_dest_q;
   assign err_credit = err_credit_q;

endmodule
`default_nettype wire

// File: tb/tb_tree_node_dispatch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_tree_node_dispatch : scoreboard bench for tree_node_dispatch         |
// | Revision              : 1.0                                           |
// +-----------------------------------------------------------------------+
module tb_tree_node_dispatch;

   localparam int N  = 5;
   localparam int DW = 32;
   localparam int CR = 4;
   localparam int SW = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              s_valid, s_ready, s_bcast;
   logic [DW-1:0]     s_data;
   logic [SW-1:0]     s_dest;
   logic [N-1:0]      m_valid, m_ready, done_i;
   logic [N*DW-1:0]   m_data;
   logic              busy, err_dest, err_credit;
   logic [N*16-1:0]   stat_cnt;

   always #5 clk = ~clk;

   tree_node_dispatch #(
      .NUM_CHILDREN (N),
      .DATA_W       (DW),
      .CREDITS      (CR),
      .SEL_W        (SW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_dest     (s_dest),
      .s_bcast    (s_bcast),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .done_i     (done_i),
      .busy       (busy),
      .err_dest   (err_dest),
      .err_credit (err_credit),
      .stat_cnt   (stat_cnt)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: abstract per-child occupancy, credit counts and expected deliveries.
   bit            full [N];
   int            credit [N];
   int            stat [N];
   bit            in_bcast;
   bit            exp_err_dest, exp_err_credit;
   logic [DW-1:0] exp_q [N][$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         full[i]   = 1'b0;
         credit[i] = CR;
         stat[i]   = 0;
         exp_q[i].delete();
      end
      in_bcast       = 1'b0;
      exp_err_dest   = 1'b0;
      exp_err_credit = 1'b0;
   endtask

   function automatic bit model_ready();
      if (!rst_n || in_bcast) return 1'b0;
      if (s_bcast) begin
         for (int i = 0; i < N; i++)
            if (full[i] || credit[i] == 0) return 1'b0;
         return 1'b1;
      end
      if (int'(s_dest) >= N) return 1'b1;
      return !full[s_dest] && credit[s_dest] > 0;
   endfunction

   function automatic logic [15:0] exp_stat(input int i);
`ifdef TREE_NODE_STATS_EN
      return 16'(stat[i]);
`else
      return 16'(0 * i);
`endif
   endfunction

   task automatic rst_check(input string tag);
      chk({tag, "_s_ready"}, 64'(s_ready), 64'(0));
      chk({tag, "_m_valid"}, 64'(m_valid), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_err_dest"}, 64'(err_dest), 64'(0));
      chk({tag, "_err_credit"}, 64'(err_credit), 64'(0));
      for (int i = 0; i < N; i++) begin
         chk($sformatf("%s_m_data[%0d]", tag, i), 64'(m_data[i*DW +: DW]), 64'(0));
         chk($sformatf("%s_stat[%0d]", tag, i), 64'(stat_cnt[i*16 +: 16]), 64'(0));
      end
   endtask

   // Inputs for this cycle are already driven; check outputs, then advance the model.
   task automatic step();
      bit rdy, acc, any, nb, ld, dr;
      #1;
      any = in_bcast;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("m_valid[%0d]", i), 64'(m_valid[i]), 64'(full[i]));
         chk($sformatf("stat[%0d]", i), 64'(stat_cnt[i*16 +: 16]), 64'(exp_stat(i)));
         any |= full[i];
      end
      chk("busy", 64'(busy), 64'(any));
      chk("err_dest", 64'(err_dest), 64'(exp_err_dest));
      chk("err_credit", 64'(err_credit), 64'(exp_err_credit));
      rdy = model_ready();
      chk("s_ready", 64'(s_ready), 64'(rdy));
      acc = s_valid && rdy;

      exp_err_dest = acc && !s_bcast && int'(s_dest) >= N;
      nb = in_bcast;
      if (in_bcast) begin
         nb = 1'b0;
         for (int i = 0; i < N; i++) if (full[i] && !m_ready[i]) nb = 1'b1;
      end else if (acc && s_bcast) begin
         nb = 1'b1;
      end
      in_bcast = nb;
      for (int i = 0; i < N; i++) begin
         ld = acc && (s_bcast || int'(s_dest) == i);
         dr = full[i] && m_ready[i];
         if (ld) begin
            full[i] = 1'b1;
            exp_q[i].push_back(s_data);
         end else if (dr) begin
            full[i] = 1'b0;
         end
         if (dr && stat[i] < 65535) stat[i]++;
         if (ld && !done_i[i]) credit[i]--;
         else if (done_i[i] && !ld) begin
            if (credit[i] == CR) exp_err_credit = 1'b1;
            else                 credit[i]++;
         end
      end
      @(negedge clk);
   endtask

   task automatic drive(input bit v, input bit bc, input int dest, input logic [DW-1:0] d,
                        input logic [N-1:0] mr, input logic [N-1:0] dn);
      s_valid = v;
      s_bcast = bc;
      s_dest  = SW'(dest);
      s_data  = d;
      m_ready = mr;
      done_i  = dn;
      step();
   endtask

   task automatic restore();
      s_valid = 1'b0;
      m_ready = '1;
      for (int k = 0; k < CR + 2; k++) begin
         for (int i = 0; i < N; i++) done_i[i] = (credit[i] < CR);
         step();
      end
      done_i = '0;
   endtask

   // Monitor: every observed handshake pops that child's expected payload.
   initial begin
      bit avail;
      forever begin
         @(negedge clk);
         #3;
         for (int i = 0; i < N; i++) begin
            if (rst_n && m_valid[i] && m_ready[i]) begin
               avail = exp_q[i].size() > 0;
               chk($sformatf("delivery_expected[%0d]", i), 64'(avail), 64'(1));
               if (avail)
                  chk($sformatf("m_data[%0d]", i), 64'(m_data[i*DW +: DW]), 64'(exp_q[i].pop_front()));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b1;
      s_bcast = 1'b0;
      s_dest  = '0;
      s_data  = '0;
      m_ready = '0;
      done_i  = '0;
      model_reset();
      @(negedge clk);
      #1;
      rst_check("reset");
      @(negedge clk);
      rst_n   = 1'b1;
      s_valid = 1'b0;

      drive(1, 0, 2, 32'hA5A5_0001, '1, '0);
      drive(0, 0, 0, 0, '1, '0);
      drive(0, 0, 0, 0, '1, '0);

      for (int k = 0; k < 10; k++) drive(1, 0, 0, $urandom, '1, '0);
      drive(1, 0, 0, $urandom, '1, 5'b00001);
      drive(1, 0, 0, $urandom, '1, '0);
      drive(0, 0, 0, 0, '1, '0);
      restore();

      drive(1, 1, 0, 32'hDEAD_BEEF, 5'b10101, '0);
      for (int k = 0; k < 3; k++) drive(1, 0, 1, 32'h0000_1111, 5'b10101, '0);
      for (int k = 0; k < 4; k++) drive(1, 0, 1, 32'h0000_1111, '1, '0);
      restore();

      drive(1, 0, 6, 32'h0BAD_0006, '1, '0);
      drive(0, 0, 0, 0, '1, '0);
      drive(0, 0, 0, 0, '1, '0);

      drive(1, 0, 3, 32'h3333_0003, '1, 5'b01000);
      for (int k = 0; k < 10; k++) drive(1, 0, 3, $urandom, '1, '0);
      restore();

      for (int k = 0; k < 600; k++) begin
         logic [N-1:0] dn;
         for (int i = 0; i < N; i++) dn[i] = (credit[i] < CR) && ($urandom_range(0, 2) == 0);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7),
               $urandom, N'($urandom), dn);
      end
      restore();

      drive(0, 0, 0, 0, '1, 5'b00010);
      drive(0, 0, 0, 0, '1, '0);
      drive(0, 0, 0, 0, '1, '0);

      for (int k = 0; k < 3; k++) begin
         drive(1, 0, 4, $urandom, '1, '0);
         drive(0, 0, 0, 0, '1, 5'b10000);
      end

      drive(1, 1, 0, 32'hCAFE_F00D, '0, '0);
      s_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      rst_check("async_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 10; k++) drive(1, 0, 0, $urandom, '1, '0);
      restore();
      for (int i = 0; i < N; i++)
         chk($sformatf("leftover[%0d]", i), 64'(exp_q[i].size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tree_node_dispatch.md
# tree_node_dispatch

Parametrised hierarchy node that accepts a single upstream request stream and dispatches each request to one of `NUM_CHILDREN` child channels (unicast) or to all of them (broadcast). Each child has a one-entry output slot and a credit counter replenished by a child completion pulse. It sits at every internal level of the module tree, replacing fixed hand-instantiated fan-out with a flow-controlled, width- and fan-out-configurable node.

## Interface
Parameters:
- `NUM_CHILDREN`, 5, number of child channels (1..16)
- `DATA_W`, 32, request payload width
- `CREDITS`, 4, initial and maximum credits per child (1..15)
- `SEL_W`, `$clog2(NUM_CHILDREN)` (min 1), destination index width

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `s_valid`  in  1  upstream request valid
- `s_ready`  out  1  upstream request accepted when high with `s_valid`
- `s_data`  in  DATA_W  request payload
- `s_dest`  in  SEL_W  destination child index (unicast)
- `s_bcast`  in  1  broadcast to all children; `s_dest` ignored
- `m_valid`  out  NUM_CHILDREN  per-child slot valid
- `m_ready`  in  NUM_CHILDREN  per-child accept
- `m_data`  out  NUM_CHILDREN*DATA_W  per-child payload, child i at bits [i*DATA_W +: DATA_W]
- `done_i`  in  NUM_CHILDREN  per-child single-cycle completion pulse, returns one credit
- `busy`  out  1  any slot valid or FSM not IDLE
- `err_dest`  out  1  one-cycle pulse: unicast with `s_dest >= NUM_CHILDREN` dropped
- `err_credit`  out  1  sticky: `done_i` while credit already at `CREDITS`
- `stat_cnt`  out  NUM_CHILDREN*16  per-child delivered-request counters

## Operation
- FSM states: IDLE, BCAST_DRAIN.
- IDLE, unicast, `s_dest` valid: `s_ready` = slot[s_dest] empty && credit[s_dest] > 0. On transfer: slot loaded, credit decremented.
- IDLE, unicast, `s_dest` out of range: `s_ready`=1, request dropped, `err_dest` pulses next cycle; no state change.
- IDLE, broadcast: `s_ready` = all slots empty && all credits > 0. On transfer: all slots loaded with `s_data`, all credits decremented, go to BCAST_DRAIN.
- BCAST_DRAIN: `s_ready`=0; return to IDLE in the cycle after the last slot drains (ordering: no request overtakes a broadcast).
- Slot i drains on `m_valid[i] && m_ready[i]`; `m_data[i]` stable while `m_valid[i]` high.
- Credit update per child: −1 on acceptance, +1 on `done_i`; both in same cycle → unchanged. `done_i` at `CREDITS` (without simultaneous acceptance) → ignored, `err_credit` set until reset.
- `s_ready` depends combinationally on `s_dest`/`s_bcast`/state; upstream must not gate `s_valid` on `s_ready`.

## Timing
- Reset values: `s_ready`=0 during reset, all `m_valid`=0, `m_data`=0, credits=`CREDITS`, state IDLE, `busy`=0, `err_dest`=0, `err_credit`=0, `stat_cnt`=0.
- Latency: request accepted at edge k → `m_valid` high from cycle k+1.
- Slot drained at edge k may be reloaded at edge k+1 (no same-cycle drain-and-refill; max 1 request per child per 2 cycles).
- Reset asserted mid-operation: slots and in-flight broadcast discarded immediately; credits restored.

## Configuration
- `TREE_NODE_STATS_EN` defined: `stat_cnt[i]` increments on each slot-i drain, saturates at 16'hFFFF, cleared only by reset.
- Undefined: counters not built, `stat_cnt` tied to 0.

## Structure
- Package `tree_node_pkg`: FSM state enum (`TN_IDLE`, `TN_BCAST_DRAIN`), `CNT_W`=16, credit width constant (4).
- One sub-module `tree_node_slot`: per-child output slot + credit counter (+ stats counter under macro), instantiated `NUM_CHILDREN` times by generate loop; top holds FSM and `s_ready` decode.

## Test plan
- Reset, then unicast `s_dest`=2, `s_data`=32'hA5A5_0001, `m_ready`=all 1 → `m_valid`=5'b00100 one cycle after accept, data matches, credit[2] 4→3.
- Five unicasts to child 0, `m_ready[0]`=1, no `done_i` → first four accepted, fifth held `s_ready`=0; one `done_i[0]` pulse → fifth accepted next cycle.
- Broadcast 32'hDEAD_BEEF with `m_ready`=5'b10101 then remaining after 3 cycles → all 5 children receive it, `s_ready`=0 throughout BCAST_DRAIN, a pending unicast is accepted only after the last drain.
- Unicast `s_dest`=6 → accepted, no `m_valid`, `err_dest` pulses 1 cycle, credits unchanged.
- `done_i[1]` at credit 4 → `err_credit` stays 1; simultaneous accept + `done_i` on child 3 → credit unchanged.
- With `TREE_NODE_STATS_EN`: 3 drains on child 4 → `stat_cnt[4]`=3; assert `rst_n`=0 mid-broadcast → all outputs return to reset values asynchronously.
